// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / product-accumulator datapath.
// Holds the operand and product widths of the 16x9 multiplier, the product
// type and the accumulator state encoding.
package mult_pkg;

  localparam int MULTIPLIER_W   = 16;
  localparam int MULTIPLICAND_W = 9;
  localparam int PROD_W         = MULTIPLIER_W + MULTIPLICAND_W;

  typedef logic [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Stream bundle between the multiplier side, the product accumulator and the
// result consumer.
//   clear        : synchronous frame abort (environment -> accumulator)
//   in_valid     : in_product is valid          (environment -> accumulator)
//   in_ready     : accumulator takes a product  (accumulator -> environment)
//   in_product   : unsigned product             (environment -> accumulator)
//   out_valid    : frame result is valid        (accumulator -> environment)
//   out_ready    : consumer takes the result    (environment -> accumulator)
//   out_sum      : saturated frame total        (accumulator -> environment)
//   out_overflow : saturation hit in the frame  (accumulator -> environment)
// modport master is the environment side, modport slave the accumulator.
interface product_accumulator_if #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int ACC_W  = 32
);

  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;

  modport master (
    output clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

  modport slave (
    input  clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Combinational ACC_W-bit unsigned adder with saturation.
//   a, b  : addends
//   sum   : a + b, clamped to all-ones when the true sum does not fit
//   carry : high when the true sum exceeded 2^ACC_W - 1
module sat_adder #(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  // Returns {carry, saturated sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x,
                                             input logic [ACC_W-1:0] y);
    logic [ACC_W:0] raw;
    raw = {1'b0, x} + {1'b0, y};
    if (raw[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return raw;
  endfunction

  logic [ACC_W:0] res;

  assign res   = sat_add(a, b);
  assign sum   = res[ACC_W-1:0];
  assign carry = res[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// Frames the multiplier's product stream: sums FRAME_LEN accepted products
// into a saturating accumulator and offers each frame total on a
// valid/ready result port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : product_accumulator_if.slave (clear, input stream, result port)
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W    = mult_pkg::PROD_W,
  parameter int ACC_W     = 32,
  parameter int FRAME_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);

  localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum_w;
  logic             carry_w;
  logic             ovf_next;
  logic             accept;

  assign prod_ext = ACC_W'(bus.in_product);

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .a     (acc_q),
    .b     (prod_ext),
    .sum   (sum_w),
    .carry (carry_w)
  );

  // Ready depends on state only, so DONE->IDLE never passes a product through.
  assign bus.in_ready     = (state_q != DONE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_sum      = out_sum_q;
  assign bus.out_overflow = out_ovf_q;

  assign accept   = bus.in_valid && bus.in_ready && !bus.clear;
  assign ovf_next = ovf_q | carry_w;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;

    if (bus.clear) begin
      state_d   = IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      out_sum_d = '0;
      out_ovf_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d = sum_w;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_next;
            if (cnt_q == LAST_CNT) begin
              // Final product of the frame: capture the total as it lands.
              state_d   = DONE;
              out_sum_d = sum_w;
              out_ovf_d = ovf_next;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            out_sum_d = '0;
            out_ovf_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default instance (ACC_W=32,
// FRAME_LEN=8) and a narrow instance (ACC_W=26, FRAME_LEN=4) for saturation.
module tb_product_accumulator;

  localparam logic [24:0] P1   = 25'd3709800;   // 0x6B58 * 0x087
  localparam logic [24:0] P2   = 25'd7258848;   // 0xAAD0 * 0x0A6
  localparam logic [24:0] PBIG = 25'd33488385;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  product_accumulator_if #(.PROD_W(25), .ACC_W(32)) bus_m ();
  product_accumulator_if #(.PROD_W(25), .ACC_W(26)) bus_s ();

  product_accumulator #(.PROD_W(25), .ACC_W(32), .FRAME_LEN(8)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  product_accumulator #(.PROD_W(25), .ACC_W(26), .FRAME_LEN(4)) u_narrow (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_m.clear = 1'b0; bus_m.in_valid = 1'b0; bus_m.in_product = '0; bus_m.out_ready = 1'b0;
    bus_s.clear = 1'b0; bus_s.in_valid = 1'b0; bus_s.in_product = '0; bus_s.out_ready = 1'b0;

    // Reset values
    #3;
    check("rst_in_ready", bus_m.in_ready, 1);
    check("rst_out_valid", bus_m.out_valid, 0);
    check("rst_out_sum", bus_m.out_sum, 0);
    check("rst_out_ovf", bus_m.out_overflow, 0);
    check("rst_n_in_ready", bus_s.in_ready, 1);
    check("rst_n_out_valid", bus_s.out_valid, 0);
    #9;
    rst_n = 1'b1;

    // Frame of alternating products, consumer always ready
    bus_m.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = i[0] ? P2 : P1;
      step();
      check("t1_out_valid", bus_m.out_valid, (i == 7));
    end
    check("t1_out_sum", bus_m.out_sum, 43874592);
    check("t1_out_ovf", bus_m.out_overflow, 0);
    check("t1_in_ready_done", bus_m.in_ready, 0);
    bus_m.in_product = 25'd5;               // offered in DONE->IDLE cycle, must be ignored
    step();
    check("t1_valid_drop", bus_m.out_valid, 0);
    check("t1_in_ready_idle", bus_m.in_ready, 1);
    check("t1_sum_zero", bus_m.out_sum, 0);

    // Same frame with back-pressure
    bus_m.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = i[0] ? P2 : P1;
      step();
      check("t2_out_valid", bus_m.out_valid, (i == 7));
    end
    check("t2_out_sum", bus_m.out_sum, 43874592);
    bus_m.in_product = 25'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_valid", bus_m.out_valid, 1);
      check("t2_hold_sum", bus_m.out_sum, 43874592);
      check("t2_hold_in_ready", bus_m.in_ready, 0);
    end
    bus_m.out_ready = 1'b1;
    step();
    check("t2_xfer_valid", bus_m.out_valid, 0);
    check("t2_xfer_in_ready", bus_m.in_ready, 1);
    bus_m.in_valid = 1'b0;

    // Gapped input stream of 1s
    for (int i = 0; i < 8; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = 25'd1;
      step();
      check("t3_out_valid", bus_m.out_valid, (i == 7));
      bus_m.in_valid   = 1'b0;
      bus_m.in_product = 25'd99;
      if (i < 7) begin
        for (int g = 0; g <= i % 3; g++) begin
          step();
          check("t3_gap_valid", bus_m.out_valid, 0);
        end
      end
    end
    check("t3_out_sum", bus_m.out_sum, 8);
    step();
    check("t3_xfer_valid", bus_m.out_valid, 0);

    // Clear mid-frame drops partial frame and the concurrent product
    for (int i = 0; i < 3; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = 25'd100;
      step();
    end
    bus_m.clear = 1'b1;
    step();
    check("t4_clr_valid", bus_m.out_valid, 0);
    check("t4_clr_in_ready", bus_m.in_ready, 1);
    bus_m.clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = 25'd10;
      step();
      check("t4_out_valid", bus_m.out_valid, (i == 7));
    end
    check("t4_out_sum", bus_m.out_sum, 80);
    bus_m.in_valid = 1'b0;
    step();

    // Clear while a result is pending
    bus_m.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = 25'd10;
      step();
    end
    bus_m.in_valid = 1'b0;
    step();
    check("t4b_pending_valid", bus_m.out_valid, 1);
    bus_m.clear = 1'b1;
    step();
    check("t4b_clr_valid", bus_m.out_valid, 0);
    check("t4b_clr_sum", bus_m.out_sum, 0);
    check("t4b_clr_in_ready", bus_m.in_ready, 1);
    bus_m.clear     = 1'b0;
    bus_m.out_ready = 1'b1;

    // Asynchronous reset after 5 accepts
    for (int i = 0; i < 5; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = 25'd7;
      step();
    end
    bus_m.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("t5_rst_in_ready", bus_m.in_ready, 1);
    check("t5_rst_valid", bus_m.out_valid, 0);
    check("t5_rst_sum", bus_m.out_sum, 0);
    check("t5_rst_ovf", bus_m.out_overflow, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = 25'd2;
      step();
      check("t5_out_valid", bus_m.out_valid, (i == 7));
    end
    check("t5_out_sum", bus_m.out_sum, 16);
    bus_m.in_valid = 1'b0;
    step();

    // Asynchronous reset while a result is pending
    bus_m.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_m.in_valid   = 1'b1;
      bus_m.in_product = 25'd3;
      step();
    end
    bus_m.in_valid = 1'b0;
    check("t5b_done_sum", bus_m.out_sum, 24);
    rst_n = 1'b0;
    #2;
    check("t5b_rst_valid", bus_m.out_valid, 0);
    check("t5b_rst_sum", bus_m.out_sum, 0);
    check("t5b_rst_in_ready", bus_m.in_ready, 1);
    #3;
    rst_n = 1'b1;
    bus_m.out_ready = 1'b1;

    // Saturation on the narrow instance, then a clean frame
    bus_s.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_s.in_valid   = 1'b1;
      bus_s.in_product = PBIG;
      step();
      check("t6_out_valid", bus_s.out_valid, (i == 3));
    end
    check("t6_sat_sum", bus_s.out_sum, 26'h3FFFFFF);
    check("t6_sat_ovf", bus_s.out_overflow, 1);
    bus_s.in_valid = 1'b0;
    step();
    check("t6_xfer_valid", bus_s.out_valid, 0);
    check("t6_xfer_ovf", bus_s.out_overflow, 0);
    for (int i = 0; i < 4; i++) begin
      bus_s.in_valid   = 1'b1;
      bus_s.in_product = 25'd1;
      step();
      check("t6b_out_valid", bus_s.out_valid, (i == 3));
    end
    check("t6b_sum", bus_s.out_sum, 4);
    check("t6b_ovf", bus_s.out_overflow, 0);
    bus_s.in_valid = 1'b0;
    step();
    check("t6b_xfer_valid", bus_s.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
